// File: rtl/and4_sweep_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : and4_sweep_ctrl                                            |
// | Description : Drives all 16 {a,b,c,d} input patterns into a four-input   |
// |               AND gate, holds each for HOLD_CYCLES clocks, samples the   |
// |               gate output on the last hold clock and reports mismatches. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module and4_sweep_ctrl #(
    parameter int HOLD_CYCLES = 4,   // legal range 2..255
    parameter int ERR_W       = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    input  logic             e,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic             first_err_vld,
    output logic [3:0]       first_err_pat
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_DRIVE  = 2'd1;
    localparam logic [1:0] c_SAMPLE = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    // DRIVE covers all hold clocks but the last; SAMPLE is the final one.
    localparam logic [7:0]       c_HOLD_LAST = 8'(HOLD_CYCLES - 2);
    localparam logic [ERR_W-1:0] c_ERR_MAX   = '1;
    localparam logic [ERR_W-1:0] c_ERR_ONE   = {{(ERR_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [3:0]       r_pattern;
    logic [7:0]       r_hold_cnt;
    logic [3:0]       r_abcd;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [ERR_W-1:0] r_err_cnt;
    logic             r_first_err_vld;
    logic [3:0]       r_first_err_pat;

    logic             w_expected;
    logic             w_mismatch;
    logic [ERR_W-1:0] w_err_next;

    // Only the all-ones pattern should make the AND gate output high.
    assign w_expected = (r_pattern == 4'hF);
    assign w_mismatch = (e != w_expected);
    assign w_err_next = (w_mismatch && (r_err_cnt != c_ERR_MAX)) ?
                        (r_err_cnt + c_ERR_ONE) : r_err_cnt;

    // Sweep sequencer: state, pattern stepping, error accounting and outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= c_IDLE;
            r_pattern       <= 4'd0;
            r_hold_cnt      <= 8'd0;
            r_abcd          <= 4'd0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
            r_err_cnt       <= '0;
            r_first_err_vld <= 1'b0;
            r_first_err_pat <= 4'd0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (abort) begin
                        r_state <= c_IDLE;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                    end else if (start) begin
                        r_state         <= c_DRIVE;
                        r_pattern       <= 4'd0;
                        r_hold_cnt      <= 8'd0;
                        r_abcd          <= 4'd0;
                        r_busy          <= 1'b1;
                        r_done          <= 1'b0;
                        r_pass          <= 1'b0;
                        r_err_cnt       <= '0;
                        r_first_err_vld <= 1'b0;
                        r_first_err_pat <= 4'd0;
                    end
                end
                c_DRIVE: begin
                    if (abort) begin
                        // Partial error results stay visible until next start.
                        r_state <= c_IDLE;
                        r_abcd  <= 4'd0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                        if (r_hold_cnt == c_HOLD_LAST) begin
                            r_state <= c_SAMPLE;
                        end
                    end
                end
                c_SAMPLE: begin
                    if (abort) begin
                        r_state <= c_IDLE;
                        r_abcd  <= 4'd0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_err_cnt <= w_err_next;
                        if (w_mismatch && !r_first_err_vld) begin
                            r_first_err_vld <= 1'b1;
                            r_first_err_pat <= r_pattern;
                        end
                        if (r_pattern == 4'hF) begin
                            // Completion is keyed on 15, so the counter never wraps.
                            r_state <= c_DONE;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == '0);
                            r_abcd  <= 4'd0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state    <= c_DRIVE;
                            r_pattern  <= r_pattern + 4'd1;
                            r_abcd     <= r_pattern + 4'd1;
                            r_hold_cnt <= 8'd0;
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign {a, b, c, d}  = r_abcd;
    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign err_cnt       = r_err_cnt;
    assign first_err_vld = r_first_err_vld;
    assign first_err_pat = r_first_err_pat;

endmodule
`default_nettype wire
